// File: rtl/pc_unit.sv
// Program counter and fetch-redirect stage: owns the PC, resolves branch/jump/jr targets, traps illegal PCs.
// Latency: redirect decision to new pc is 1 cycle; first valid fetch is 1 cycle after reset deasserts.
// Backpressure: stall holds pc and defers any taken branch until stall drops; no flush while stalled.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   stall                   hazard unit hold request
//   idValid, isBranch       ID stage has a real instruction / comparator says take the redirect
//   jumpSel                 00 relative, 01 absolute, 10 register (jr), 11 reserved (illegal)
//   idPcPlus4, immExt,
//   jumpAddr, rsData        target operands from ID
//   pc, pcPlus4             current fetch address and its +4 (mod 2^32)
//   fetchValid, flush       IF output valid / squash IF/ID this cycle
//   fault, faultPc          sticky illegal-PC trap and the offending address
//   branchCount             saturating count of legal redirects (only with PC_BRANCH_COUNT_EN)
//
// Build option: define PC_BRANCH_COUNT_EN to add the branchCount output and counter.
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] IMEM_BYTES   = 32'h0000_1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        idValid,
  input  logic        isBranch,
  input  logic [1:0]  jumpSel,
  input  logic [31:0] idPcPlus4,
  input  logic [31:0] immExt,
  input  logic [25:0] jumpAddr,
  input  logic [31:0] rsData,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        fetchValid,
  output logic        flush,
  output logic        fault,
  output logic [31:0] faultPc
`ifdef PC_BRANCH_COUNT_EN
  ,
  output logic [31:0] branchCount
`endif
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [1:0]  state;
  logic [31:0] target;
  logic        target_bad;
  logic        redirect;
  logic        seq_bad;

  assign pcPlus4 = pc + 32'd4;

  always_comb begin
    target = rsData;
    case (jumpSel)
      2'b00:   target = idPcPlus4 + (immExt << 2);
      2'b01:   target = {idPcPlus4[31:28], jumpAddr, 2'b00};
      default: target = rsData;  // 11 is rejected below regardless of value
    endcase
  end

  assign target_bad = (jumpSel == 2'b11) || (target[1:0] != 2'b00) || (target >= IMEM_BYTES);

  // Stall masks the redirect entirely: operands may be stale, so the branch is
  // re-evaluated once the hazard clears.
  assign redirect   = (state == ST_RUN) && idValid && isBranch && !stall;
  assign flush      = redirect;
  assign fetchValid = (state == ST_RUN);

  // Running off the end of imem, including 32-bit wrap to zero.
  assign seq_bad = (pcPlus4 >= IMEM_BYTES) || (pcPlus4 == 32'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      pc      <= RESET_VECTOR;
      state   <= ST_BOOT;
      fault   <= 1'b0;
      faultPc <= 32'd0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (redirect && !target_bad) begin
            pc <= target;
          end else if (redirect) begin
            faultPc <= target;
            fault   <= 1'b1;
            state   <= ST_FAULT;
          end else if (stall) begin
            pc <= pc;
          end else if (seq_bad) begin
            faultPc <= pcPlus4;
            fault   <= 1'b1;
            state   <= ST_FAULT;
          end else begin
            pc <= pcPlus4;
          end
        end
        ST_FAULT: state <= ST_FAULT;
        default: begin
          // Unreachable encoding: park in the trap rather than fetch garbage.
          fault <= 1'b1;
          state <= ST_FAULT;
        end
      endcase
    end
  end

`ifdef PC_BRANCH_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      branchCount <= 32'd0;
    end else if (redirect && !target_bad && (branchCount != 32'hFFFF_FFFF)) begin
      branchCount <= branchCount + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter and fetch-redirect stage of the mips32 pipeline.
- Sits directly downstream of the ID-stage branch comparator. It consumes isBranch, plus the branch/jump operands, and produces the fetch address for the IF stage.
- Owns the PC register, computes branch/jump/jr targets, squashes the wrong-path fetch and traps illegal targets.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- IMEM_BYTES, 32'h0000_1000, instruction-memory size in bytes. Legal PCs are 0..IMEM_BYTES-4.

Ports:
- clock  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit: hold PC and IF/ID
- idValid  in  1  ID stage holds a real instruction
- isBranch  in  1  comparator result: take the redirect
- jumpSel  in  2  00 relative (beq/bne), 01 absolute (j/jal), 10 register (jr), 11 reserved
- idPcPlus4  in  32  PC+4 of the instruction in ID
- immExt  in  32  sign-extended 16-bit immediate
- jumpAddr  in  26  j/jal instr_index field
- rsData  in  32  forwarded rs value (jr target)
- pc  out  32  current fetch address
- pcPlus4  out  32  pc+4 (combinational, mod 2^32)
- fetchValid  out  1  IF output valid
- flush  out  1  squash IF/ID this cycle (load nop)
- fault  out  1  sticky illegal-PC trap
- faultPc  out  32  offending address

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high.
- Reset values: pc=RESET_VECTOR, state=BOOT, fetchValid=0, flush=0, fault=0, faultPc=0. Reset overrides everything in every state, including mid-redirect and FAULT.
- States: BOOT, RUN, FAULT.
- BOOT:
  - pc held at RESET_VECTOR; fetchValid=0; flush=0; redirect inputs ignored.
  - Next cycle -> RUN unconditionally.
- Target computation (combinational, all arithmetic mod 2^32):
  - 00: idPcPlus4 + (immExt<<2)
  - 01: {idPcPlus4[31:28], jumpAddr, 2'b00}
  - 10: rsData
  - 11: always illegal
- A target is illegal if target[1:0]!=0, target>=IMEM_BYTES, or jumpSel==11.
- redirect = (state==RUN) & idValid & isBranch & ~stall.
- RUN, priority order:
  1. redirect with legal target: flush=1 combinationally this cycle; pc<=target at the edge. No delay slot; the wrong-path fetch is squashed by flush.
  2. redirect with illegal target: flush=1; pc held; faultPc<=target; fault<=1; -> FAULT.
  3. stall=1: pc held; flush=0. A taken branch in the same cycle is deferred; stall wins because operands may be stale. It is re-evaluated when stall drops.
  4. Else sequential fetch: if pc+4 >= IMEM_BYTES, or pc+4 wraps to 0, then faultPc<=pc+4, fault<=1, -> FAULT. Otherwise pc<=pc+4.
- fetchValid = (state==RUN).
- isBranch with idValid=0 is ignored (no flush, no redirect).
- FAULT:
  - pc frozen; fetchValid=0; flush=0; fault=1; faultPc stable.
  - All inputs ignored; exit only via reset.
- Latency: redirect decision to new pc visible is 1 cycle. The first valid fetch is 1 cycle after reset deasserts.
- pcPlus4 always equals pc+4 mod 2^32, in all states.

Optional Feature:
- Macro: PC_BRANCH_COUNT_EN.
- Defined:
  - Extra output port branchCount [31:0], reset to 0.
  - Increments by 1 on each cycle with a redirect to a legal target.
  - Saturates at 32'hFFFF_FFFF.
  - Does not count stalled, invalid or faulting redirects.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then release -> cycle 0: pc=0, fetchValid=0; cycle 1: fetchValid=1, pc=0; next edges: pc=4, 8, 12.
- RUN, idValid=1, isBranch=1, jumpSel=00, idPcPlus4=0x10, immExt=0xFFFF_FFFE -> flush=1 same cycle; next pc=0x08.
- jumpSel=01, idPcPlus4=0x0000_0104, jumpAddr=0x40 -> next pc=0x100. Same inputs with stall=1 -> flush=0, pc unchanged; drop stall -> redirect to 0x100.
- jumpSel=10, rsData=0x0000_0202 -> flush=1, fault=1, faultPc=0x202, pc held, fetchValid=0; later isBranch pulses have no effect; reset clears fault, pc=RESET_VECTOR.
- Sequential fetch from pc=0xFFC with IMEM_BYTES=0x1000 -> FAULT, faultPc=0x1000. Also isBranch=1 with idValid=0 -> no flush, pc advances by 4.
- PC_BRANCH_COUNT_EN defined: 3 legal redirects, 1 stalled, 1 with idValid=0 -> branchCount=3. Preloaded at 0xFFFF_FFFF, one more redirect -> stays 0xFFFF_FFFF.
